// File: rtl/cla_pkg.sv
// Shared definitions for the CLA-family stages: word width, serial-stage state
// encoding and the carry/overflow recovery helper.
package cla_pkg;

    localparam int unsigned WORD_W = 16;

    typedef enum logic {
        FIRST = 1'b0,
        NEXT  = 1'b1
    } state_e;

    // Recovers {cout, ovf} from the MSBs, since the CLA exposes only the sum.
    function automatic logic [1:0] cla_carry_ovf(input logic a15, input logic b15, input logic s15);
        logic cout;
        logic ovf;
        cout = (a15 & b15) | ((a15 | b15) & ~s15);
        ovf  = (a15 == b15) & (s15 != a15);
        return {cout, ovf};
    endfunction

endpackage

// File: rtl/cla_16bit.sv
// Combinational 16-bit carry-lookahead adder: four 4-bit groups with
// group generate/propagate feeding the group carry-ins.
module cla_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum
);

    logic [15:0] p;
    logic [15:0] c;
    logic [2:0]  gg;
    logic [2:0]  gp;

    assign p = a ^ b;

    always_comb begin
        gg = '0;
        gp = '0;
        c  = '0;
        // Group generate/propagate for the three groups whose carry-out is consumed.
        for (int k = 0; k < 3; k++) begin
            gg[k] = 1'b0;
            gp[k] = 1'b1;
            for (int i = 0; i < 4; i++) begin
                gg[k] = (a[4*k+i] & b[4*k+i]) | (p[4*k+i] & gg[k]);
                gp[k] = gp[k] & p[4*k+i];
            end
        end
        c[0] = cin;
        for (int k = 0; k < 3; k++) begin
            c[4*k+4] = gg[k] | (gp[k] & c[4*k]);
        end
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 3; i++) begin
                c[4*k+i+1] = (a[4*k+i] & b[4*k+i]) | (p[4*k+i] & c[4*k+i]);
            end
        end
    end

    assign sum = p ^ c;

endmodule

// File: rtl/cla_serial_adder.sv
// Word-serial multi-precision adder in front of cla_16bit, LSW first, carry chained
// through a register. Define CLA_SERIAL_SUB_EN to add the in_sub subtract mode.
module cla_serial_adder
    import cla_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_a,
    input  logic [WORD_W-1:0] in_b,
    input  logic              in_cin,
    input  logic              in_last,
`ifdef CLA_SERIAL_SUB_EN
    input  logic              in_sub,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_sum,
    output logic              out_last,
    output logic [CNT_W-1:0]  out_idx,
    output logic              out_cout,
    output logic              out_ovf
);

    state_e             state_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               out_valid_q;
    logic [WORD_W-1:0]  out_sum_q;
    logic               out_last_q;
    logic [CNT_W-1:0]   out_idx_q;
    logic               out_cout_q;
    logic               out_ovf_q;

    logic               sub_c;
    logic               cin_c;
    logic [WORD_W-1:0]  b_eff_c;
    logic [WORD_W-1:0]  sum_c;
    logic [1:0]         flags_c;
    logic               xfer_in_c;
    logic               xfer_out_c;

`ifdef CLA_SERIAL_SUB_EN
    logic               sub_q;
    // Mode is taken from the LSW and held for the rest of the packet.
    assign sub_c = (state_q == FIRST) ? in_sub : sub_q;
`else
    assign sub_c = 1'b0;
`endif

    assign b_eff_c    = sub_c ? ~in_b : in_b;
    assign cin_c      = (state_q == NEXT) ? carry_q : (sub_c | in_cin);
    assign in_ready   = !out_valid_q | out_ready;
    assign xfer_in_c  = in_valid & in_ready;
    assign xfer_out_c = out_valid_q & out_ready;

    cla_16bit u_cla (
        .a   (in_a),
        .b   (b_eff_c),
        .cin (cin_c),
        .sum (sum_c)
    );

    assign flags_c = cla_carry_ovf(in_a[WORD_W-1], b_eff_c[WORD_W-1], sum_c[WORD_W-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FIRST;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
`ifdef CLA_SERIAL_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else if (xfer_in_c) begin
            state_q     <= in_last ? FIRST : NEXT;
            carry_q     <= flags_c[1];
            cnt_q       <= in_last ? '0 : cnt_q + CNT_W'(1);
            out_valid_q <= 1'b1;
            out_sum_q   <= sum_c;
            out_last_q  <= in_last;
            out_idx_q   <= cnt_q;
            out_cout_q  <= in_last & flags_c[1];
            out_ovf_q   <= in_last & flags_c[0];
`ifdef CLA_SERIAL_SUB_EN
            sub_q       <= sub_c;
`endif
        end else if (xfer_out_c) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_last  = out_last_q;
    assign out_idx   = out_idx_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_cla_serial_adder.sv
// Bench for cla_serial_adder: directed and random packets checked against a
// whole-packet big-integer reference model. Honours CLA_SERIAL_SUB_EN.
module tb_cla_serial_adder;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned MAXW  = 16;
    localparam int unsigned BW    = 16 * MAXW + 1;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_a;
    logic [15:0]       in_b;
    logic              in_cin;
    logic              in_last;
`ifdef CLA_SERIAL_SUB_EN
    logic              in_sub;
`endif
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_sum;
    logic              out_last;
    logic [CNT_W-1:0]  out_idx;
    logic              out_cout;
    logic              out_ovf;

    int checks;
    int errors;

    logic [15:0] wa [MAXW];
    logic [15:0] wb [MAXW];

    cla_serial_adder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_last   (in_last),
`ifdef CLA_SERIAL_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_idx   (out_idx),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Whole packet as one wide integer; expected words are slices of the exact result.
    task automatic run_packet(input int n, input logic cin, input logic sub, input bit bubbles);
        logic [BW-1:0] A, B, T, one, mask;
        logic          cout, ovf, sa, sb, sr, lst;
        A    = '0;
        B    = '0;
        one  = BW'(1);
        mask = (one << (16 * n)) - one;
        for (int k = 0; k < n; k++) begin
            A[16*k +: 16] = wa[k];
            B[16*k +: 16] = wb[k];
        end
        if (sub) T = A + ((~B) & mask) + one;
        else     T = A + B + BW'(cin);
        cout = T[16*n];
        sa   = A[16*n-1];
        sb   = sub ? ~B[16*n-1] : B[16*n-1];
        sr   = T[16*n-1];
        ovf  = (sa == sb) && (sr != sa);
        for (int k = 0; k < n; k++) begin
            if (bubbles && k > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            lst      = (k == n - 1);
            in_valid = 1'b1;
            in_a     = wa[k];
            in_b     = wb[k];
            in_cin   = (k == 0) ? cin : logic'($urandom_range(0, 1));
            in_last  = lst;
`ifdef CLA_SERIAL_SUB_EN
            in_sub   = (k == 0) ? sub : logic'($urandom_range(0, 1));
`endif
            @(posedge clk);
            #1;
            chk("valid", 32'(out_valid), 32'd1);
            chk("sum",   32'(out_sum),   32'(T[16*k +: 16]));
            chk("idx",   32'(out_idx),   32'(k));
            chk("last",  32'(out_last),  32'(lst));
            chk("cout",  32'(out_cout),  32'(lst & cout));
            chk("ovf",   32'(out_ovf),   32'(lst & ovf));
        end
    endtask

    initial begin
        int n;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
`ifdef CLA_SERIAL_SUB_EN
        in_sub    = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sum",   32'(out_sum),   32'd0);
        chk("rst_idx",   32'(out_idx),   32'd0);
        chk("rst_flags", {30'd0, out_cout, out_ovf}, 32'd0);
        chk("rst_ready", 32'(in_ready),  32'd1);
        rst_n = 1'b1;

        // 32-bit add with carry across the word boundary
        wa[0] = 16'hFFFF; wb[0] = 16'h0001;
        wa[1] = 16'h0001; wb[1] = 16'h0000;
        run_packet(2, 1'b0, 1'b0, 1'b0);
        chk("add32_msw", 32'(out_sum), 32'h0002);

        // Single-word signed overflow, then carry-in producing carry-out
        wa[0] = 16'h7FFF; wb[0] = 16'h0001;
        run_packet(1, 1'b0, 1'b0, 1'b0);
        chk("ovf_sum", {15'd0, out_ovf, out_sum}, 32'h0001_8000);
        wa[0] = 16'hFFFF; wb[0] = 16'h0000;
        run_packet(1, 1'b1, 1'b0, 1'b0);
        chk("cout_sum", {15'd0, out_cout, out_sum}, 32'h0001_0000);

        // A sum word that is never accepted drains when the input idles
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drain", 32'(out_valid), 32'd0);

        // Backpressure mid-packet: LSW produces carry, MSW waits behind a stall
        in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0001; in_cin = 1'b0; in_last = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_lsw", 32'(out_sum), 32'h0000);
        out_ready = 1'b0;
        in_a = 16'h0001; in_b = 16'h0000; in_cin = 1'b0; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold", {7'd0, out_valid, out_idx, out_sum}, {7'd0, 1'b1, 8'd0, 16'h0000});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_msw", {6'd0, out_cout, out_last, out_idx, out_sum}, {6'd0, 1'b0, 1'b1, 8'd1, 16'h0002});

        // Two 3-word packets back to back; second packet must use its own cin
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 3; k++) begin
                wa[k] = 16'hFFFF;
                wb[k] = (p == 0) ? 16'h0001 : 16'h0000;
            end
            run_packet(3, logic'(p), 1'b0, 1'b0);
        end

        // Reset mid-packet discards the carry of the partial packet
        wa[0] = 16'hFFFF; wb[0] = 16'h0001;
        run_packet(2, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0001; in_cin = 1'b0; in_last = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_out", {7'd0, out_valid, out_idx, out_sum}, 32'd0);
        wa[0] = 16'h0001; wb[0] = 16'h0001;
        run_packet(1, 1'b0, 1'b0, 1'b0);
        chk("midrst_sum", {8'd0, out_idx, out_sum}, 32'h0000_0002);

        // Word counter wraps modulo 2^CNT_W
        in_a = '0; in_b = '0; in_cin = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 257; k++) begin
            in_last = (k == 256);
            @(posedge clk);
            #1;
            if (k == 255) chk("wrap_255", 32'(out_idx), 32'd255);
            if (k == 256) chk("wrap_256", 32'(out_idx), 32'd0);
        end
        wa[0] = 16'h1234; wb[0] = 16'h4321;
        run_packet(1, 1'b0, 1'b0, 1'b0);

`ifdef CLA_SERIAL_SUB_EN
        // 0001_0000 - 0000_0001 = 0000_FFFF, no borrow
        wa[0] = 16'h0000; wb[0] = 16'h0001;
        wa[1] = 16'h0001; wb[1] = 16'h0000;
        run_packet(2, 1'b0, 1'b1, 1'b0);
        chk("sub_msw", {15'd0, out_cout, out_sum}, 32'h0001_0000);
`endif

        // Random packets with bubbles
        for (int p = 0; p < 40; p++) begin
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                wa[k] = 16'($urandom);
                wb[k] = 16'($urandom);
            end
`ifdef CLA_SERIAL_SUB_EN
            run_packet(n, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
`else
            run_packet(n, logic'($urandom_range(0, 1)), 1'b0, bit'($urandom_range(0, 1)));
`endif
        end

        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_serial_adder.md
Name: cla_serial_adder

Overview:
- Word-serial multi-precision adder stage that sits directly upstream of `cla_16bit` and drives its `a`, `b` and `cin`.
- Accepts operands as a stream of 16-bit word pairs, least-significant word first.
- Chains the carry between words in a register and registers each sum word on a valid/ready output.
- Lets the combinational 16-bit CLA perform N×16-bit additions, one word per cycle.

Parameters:
- CNT_W, 8, width of the per-packet word index counter (`out_idx`).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock, synchronous, active-low.
- in_valid  input  1  operand word pair is present.
- in_ready  output  1  stage can accept a word this cycle.
- in_a  input  16  operand A word.
- in_b  input  16  operand B word.
- in_cin  input  1  carry-in; sampled only on the first word of a packet.
- in_last  input  1  marks the most-significant word of the packet.
- out_valid  output  1  registered sum word is present.
- out_ready  input  1  downstream accepts the sum word.
- out_sum  output  16  sum word.
- out_last  output  1  sum word is the packet MSW.
- out_idx  output  CNT_W  word index within the packet (0 = LSW).
- out_cout  output  1  final carry-out; meaningful only when out_last=1, else 0.
- out_ovf  output  1  signed overflow of the full-width result; meaningful only when out_last=1, else 0.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, out_sum=0, out_last=0, out_idx=0, out_cout=0, out_ovf=0, carry register=0, word counter=0, state=FIRST.
- in_ready = !out_valid | out_ready (single-entry skid-free register). Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
- States:
  - FIRST: next accepted word is the packet LSW; the CLA cin is in_cin.
  - NEXT: the CLA cin is the carry register.
- Transitions:
  - FIRST→NEXT on a transfer-in with in_last=0.
  - NEXT→FIRST on a transfer-in with in_last=1.
  - A transfer-in with in_last=1 in FIRST (single-word packet) stays in FIRST.
- The CLA computes combinationally from in_a, in_b and the selected cin.
- Carry derivation (the CLA exposes no carry-out):
  - cout = (in_a[15] & in_b[15]) | ((in_a[15] | in_b[15]) & ~sum[15]).
  - ovf = (in_a[15] == in_b[15]) & (sum[15] != in_a[15]).
- On transfer-in (1-cycle latency): out_sum←sum, out_last←in_last, out_idx←word counter, carry register←cout, out_cout←in_last ? cout : 0, out_ovf←in_last ? ovf : 0, out_valid←1.
- Word counter: increments on each transfer-in. Cleared to 0 after a transfer-in with in_last=1. Wraps modulo 2^CNT_W on overflow with no error flag.
- Transfer-out without a simultaneous transfer-in clears out_valid. Simultaneous in and out in the same cycle: the register reloads and out_valid stays 1 (full throughput).
- Stall (out_valid=1, out_ready=0): all output fields hold stable, in_ready=0, the carry register is unchanged.
- in_valid=0 mid-packet: state and carry register are held indefinitely (bubbles allowed).
- Reset asserted mid-packet: the partial packet is discarded, no output is produced for it, and the next accepted word is treated as an LSW.

Optional Feature:
- Macro CLA_SERIAL_SUB_EN.
- When defined:
  - Adds input port in_sub (1 bit), sampled on the first word and held for the whole packet in a register.
  - When the held value is 1, the CLA b operand is ~in_b and the first-word cin is 1 (in_cin ignored), giving A−B. Carry chaining and the cout/ovf equations use the inverted B.
  - out_cout=1 means no borrow.
- When undefined: port absent; addition only.

Decomposition:
- Package cla_pkg:
  - WORD_W=16.
  - State enum {FIRST, NEXT}.
  - A function returning {cout, ovf} from a15, b15 and sum15, shared with other CLA-family stages.
- Sub-module: one instance of the existing `cla_16bit` (a, b, cin, sum). No other sub-modules.

Test Plan:
- 32-bit add: words (FFFF, 0001) then (0001, 0000) last, in_cin=0 → out_sum 0000 idx0 last0, then 0002 idx1 last1; cout=0, ovf=0.
- Single-word signed overflow: 7FFF+0001 last, cin=0 → out_sum 8000, ovf=1, cout=0. Then FFFF+0000 with in_cin=1 → 0000, cout=1, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles mid-packet → in_ready=0, out_sum stable, carry preserved. The next word is summed with the correct chained carry.
- Back-to-back throughput: out_ready=1 and in_valid=1 continuously, two 3-word packets → 6 outputs on 6 consecutive cycles, idx 0,1,2,0,1,2. The second packet uses its own in_cin, not the prior carry.
- Reset mid-packet: after the LSW (FFFF+0001) assert rst_n=0 for 1 cycle → outputs zeroed. Next word 0001+0001 last, cin=0 → out_sum 0002, idx0 (no stale carry).
- With CLA_SERIAL_SUB_EN: in_sub=1, 32-bit 0001_0000 − 0000_0001 → words FFFF then 0000 last, cout=1, ovf=0.
